// File: rtl/mp_add_ctrl.sv
// mp_add_ctrl: multi-precision add sequencer around one WIDTH-bit add stage.
// Operand word pairs stream in LS word first; the inter-word carry is kept
// internally and registered sum words stream out under valid/ready.
//
// Optional feature macro: MP_ADD_SUB_EN
//   defined   -> adds the 'sub' input; sub=1 computes A - B (carry_out=1 means
//                no borrow)
//   undefined -> add only, initial carry is 0
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a start with a legal word count
// RUN   | accepting operand words, one sum word per accepted pair
// DRAIN | last sum word waits for the downstream handshake

module mp_add_ctrl #(
    parameter  int WIDTH = 32,
    parameter  int MAXW  = 8,
    localparam int NW    = $clog2(MAXW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NW-1:0]    nwords,
`ifdef MP_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic             carry_out,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [NW-1:0]    cnt_q;
    logic             carry_q;
    logic             carry_out_q;
    logic             busy_q;
    logic             done_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_last_q;
`ifdef MP_ADD_SUB_EN
    logic             sub_q;
`endif

    logic [WIDTH:0]   add_d;
    logic [WIDTH-1:0] b_eff_d;
    logic             in_ready_d;
    logic             in_fire_d;
    logic             out_fire_d;
    logic             start_ok_d;
    logic             carry_init_d;
    logic             last_word_d;

    // Handshake qualification and the shared add stage for the current word.
    always_comb begin
        b_eff_d      = in_b;
        carry_init_d = 1'b0;
`ifdef MP_ADD_SUB_EN
        if (sub_q) begin
            b_eff_d = ~in_b;
        end
        carry_init_d = sub;
`endif
        add_d       = {1'b0, in_a} + {1'b0, b_eff_d} + {{WIDTH{1'b0}}, carry_q};
        in_ready_d  = (state_q == S_RUN) && (!out_valid_q || out_ready);
        in_fire_d   = in_valid && in_ready_d;
        out_fire_d  = out_valid_q && out_ready;
        start_ok_d  = start && (nwords != '0) && (nwords <= NW'(MAXW));
        last_word_d = (cnt_q == NW'(1));
    end

    // Sequencer FSM with all datapath and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok_d) begin
                        state_q     <= S_RUN;
                        busy_q      <= 1'b1;
                        cnt_q       <= nwords;
                        carry_q     <= carry_init_d;
                        carry_out_q <= 1'b0;
`ifdef MP_ADD_SUB_EN
                        sub_q       <= sub;
`endif
                    end
                end
                S_RUN: begin
                    if (in_fire_d) begin
                        out_sum_q   <= add_d[WIDTH-1:0];
                        carry_q     <= add_d[WIDTH];
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_word_d;
                        cnt_q       <= cnt_q - NW'(1);
                        if (last_word_d) begin
                            state_q     <= S_DRAIN;
                            carry_out_q <= add_d[WIDTH];
                        end
                    end else if (out_fire_d) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // The only word left in flight here is the last one.
                    if (out_fire_d) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign carry_out = carry_out_q;
    assign in_ready  = in_ready_d;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Bench for mp_add_ctrl: directed vector table, hand sequences for the
// ignored-start and mid-operation reset cases, and randomized operations
// compared against a big-number arithmetic model.
module tb_mp_add_ctrl;

    localparam int WIDTH = 32;
    localparam int MAXW  = 8;
    localparam int NW    = $clog2(MAXW + 1);
    localparam int BW    = MAXW * WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [NW-1:0]    nwords;
    logic             sub_r;
    logic             busy, done, carry_out;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             out_valid, out_ready, out_last;
    logic [WIDTH-1:0] out_sum;

    mp_add_ctrl #(.WIDTH(WIDTH), .MAXW(MAXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .nwords    (nwords),
`ifdef MP_ADD_SUB_EN
        .sub       (sub_r),
`endif
        .busy      (busy),
        .done      (done),
        .carry_out (carry_out),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [WIDTH-1:0] opa  [MAXW];
    logic [WIDTH-1:0] opb  [MAXW];
    logic [WIDTH-1:0] expw [MAXW];
    logic             expc;

    typedef struct {
        int               n;
        int               rmode;
        logic [WIDTH-1:0] a [4];
        logic [WIDTH-1:0] b [4];
        logic [WIDTH-1:0] s [4];
        logic             c;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; nwords = '0; sub_r = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Reference: whole operands as big integers, sum/difference mod 2^(n*WIDTH).
    task automatic model(input int n, input logic sv);
        logic [BW-1:0] A, B, R, M, one;
        A = '0; B = '0; one = 1;
        for (int i = 0; i < n; i++) begin
            A[i*WIDTH +: WIDTH] = opa[i];
            B[i*WIDTH +: WIDTH] = opb[i];
        end
        M = (one << (n * WIDTH)) - one;
        if (sv) begin
            R    = (A - B) & M;
            expc = (A >= B);
        end else begin
            R    = A + B;
            expc = R[n*WIDTH];
        end
        for (int i = 0; i < n; i++) expw[i] = R[i*WIDTH +: WIDTH];
    endtask

    // One full operation: rmode 0 = always ready, 1 = random, 2 = 1,0,0 pattern.
    // poke pulses start with nwords=1 while RUN, which must be ignored.
    task automatic do_op(input int n, input logic sv, input int rmode, input bit poke);
        int               idx = 0, oidx = 0, cyc = 0;
        bit               fin = 0, prev_stall = 0, held = 0, exp_ov, exp_ir, ifire, ofire;
        logic [WIDTH-1:0] prev_sum = '0;
        @(negedge clk);
        start = 1'b1; nwords = NW'(n); sub_r = sv; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("cout_cleared", carry_out, 0);
        while (!fin && cyc < 300) begin
            if (idx < n) begin
                in_valid = held ? 1'b1 : (rmode == 0 || $urandom_range(0, 3) != 0);
                in_a = opa[idx]; in_b = opb[idx];
            end else begin
                in_valid = 1'b0; in_a = '0; in_b = '0;
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc % 3 == 0);
            endcase
            if (poke && cyc == 1) begin start = 1'b1; nwords = NW'(1); end
            else start = 1'b0;
            #1;
            exp_ov = (idx > oidx);
            exp_ir = (idx < n) && (!exp_ov || out_ready);
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, exp_ir);
            check("busy_run", busy, 1);
            check("done_low", done, 0);
            if (idx == n) check("cout_drain", carry_out, expc);
            if (prev_stall) check("sum_hold", out_sum, prev_sum);
            ifire = in_valid && in_ready;
            ofire = out_valid && out_ready;
            if (ofire) begin
                check("out_sum", out_sum, (oidx < n) ? expw[oidx] : 'x);
                check("out_last", out_last, (oidx == n - 1));
                if (oidx >= n - 1) fin = 1;
                oidx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            held       = in_valid && !ifire;
            if (ifire) idx++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (!fin) begin
            check("op_timeout", 1, 0);
            do_reset();
        end else begin
            check("done_pulse", done, 1);
            check("busy_idle", busy, 0);
            check("carry_out", carry_out, expc);
            check("out_valid_idle", out_valid, 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("carry_out_hold", carry_out, expc);
        end
    endtask

    task automatic load_vec(input int k);
        for (int i = 0; i < MAXW; i++) begin
            opa[i] = (i < 4) ? tbl[k].a[i] : '0;
            opb[i] = (i < 4) ? tbl[k].b[i] : '0;
            expw[i] = (i < 4) ? tbl[k].s[i] : '0;
        end
        expc = tbl[k].c;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cout"}, carry_out, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_sum"}, out_sum, 0);
        check({tag, "_out_last"}, out_last, 0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                tbl[k].a[i] = '0; tbl[k].b[i] = '0; tbl[k].s[i] = '0;
            end
        end
        tbl[0].n = 1; tbl[0].rmode = 0; tbl[0].c = 1'b1;
        tbl[0].a[0] = 32'hFFFF_FFFF; tbl[0].b[0] = 32'h0000_0001; tbl[0].s[0] = 32'h0;
        tbl[1].n = 2; tbl[1].rmode = 0; tbl[1].c = 1'b0;
        tbl[1].a[0] = 32'hFFFF_FFFF; tbl[1].a[1] = 32'h1;
        tbl[1].b[0] = 32'h1;         tbl[1].b[1] = 32'h2;
        tbl[1].s[0] = 32'h0;         tbl[1].s[1] = 32'h4;
        tbl[2].n = 3; tbl[2].rmode = 2; tbl[2].c = 1'b1;
        tbl[2].a[0] = 32'h1; tbl[2].a[1] = 32'h2; tbl[2].a[2] = 32'h3;
        tbl[2].b[0] = 32'hFFFF_FFFF; tbl[2].b[1] = 32'hFFFF_FFFF; tbl[2].b[2] = 32'hFFFF_FFFF;
        tbl[2].s[0] = 32'h0; tbl[2].s[1] = 32'h2; tbl[2].s[2] = 32'h3;
        tbl[3].n = 4; tbl[3].rmode = 1; tbl[3].c = 1'b0;
        tbl[3].a[0] = 32'h8000_0000; tbl[3].b[0] = 32'h8000_0000; tbl[3].s[0] = 32'h0;
        tbl[3].a[1] = 32'h7FFF_FFFF; tbl[3].b[1] = 32'h0;         tbl[3].s[1] = 32'h8000_0000;
        tbl[3].a[2] = 32'h1234_5678; tbl[3].b[2] = 32'h1111_1111; tbl[3].s[2] = 32'h2345_6789;
        tbl[3].a[3] = 32'h0;         tbl[3].b[3] = 32'h0;         tbl[3].s[3] = 32'h0;

        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            load_vec(k);
            do_op(tbl[k].n, 1'b0, tbl[k].rmode, 1'b0);
        end

        // Out-of-range counts are ignored in IDLE; carry_out of the last op stays.
        for (int z = 0; z < 2; z++) begin
            @(negedge clk);
            start = 1'b1; nwords = (z == 0) ? NW'(0) : NW'(MAXW + 1);
            @(negedge clk);
            start = 1'b0;
            check("bad_n_busy", busy, 0);
            check("bad_n_done", done, 0);
            check("bad_n_cout", carry_out, 0);
            @(negedge clk);
            check("bad_n_done2", done, 0);
        end

        // start during RUN is ignored: two words still come out.
        load_vec(1);
        do_op(2, 1'b0, 0, 1'b1);

        // Reset on the cycle after the second word of a 4-word op is accepted.
        @(negedge clk);
        start = 1'b1; nwords = NW'(4); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1;
        @(negedge clk);
        in_a = 32'h1111_1111; in_b = 32'h2222_2222;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        rst_n = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        check("midrst_no_done", done, 0);
        opa[0] = 32'h0000_0005; opb[0] = 32'hFFFF_FFFE;
        model(1, 1'b0);
        do_op(1, 1'b0, 0, 1'b0);

`ifdef MP_ADD_SUB_EN
        opa[0] = 32'h0; opa[1] = 32'h1;
        opb[0] = 32'h1; opb[1] = 32'h0;
        expw[0] = 32'hFFFF_FFFF; expw[1] = 32'h0; expc = 1'b1;
        do_op(2, 1'b1, 0, 1'b0);
`endif

        for (int t = 0; t < 30; t++) begin
            int   n;
            logic sv;
            n  = $urandom_range(1, MAXW);
            sv = 1'b0;
`ifdef MP_ADD_SUB_EN
            sv = 1'($urandom_range(0, 1));
`endif
            for (int i = 0; i < MAXW; i++) begin
                opa[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                opb[i] = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
            end
            model(n, sv);
            do_op(n, sv, $urandom_range(0, 2), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
